// File: rtl/mem_access_pkg.sv
// Package: mem_access_pkg
// Shared types for the MEM stage: the inter-stage bundle (with the formatted
// load data field mdr), the MEM handshake state encoding, funct3 load/store
// width codes and a misalignment helper used when MEM_MISALIGN_CHECK_EN is set.
package mem_access_pkg;

    // funct3 encodings for RV32I loads/stores (stores use the B/H/W codes)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,   // no request outstanding
        BUSY,   // request outstanding, waiting for dmem_resp
        DONE    // response captured, waiting for the stage to advance
    } mem_state_t;

    typedef struct packed {
        logic read_b;
        logic write;
        logic load_regfile;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        ctrl_t       ctrl;
        logic [31:0] mdr;
    } stage_regs;

    // Half accesses need a[0]=0, word accesses need a[1:0]=0.
    function automatic logic access_misaligned(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Module: mem_access_align
// Combinational lane logic for the MEM stage.
//   funct3      in  access width / signedness
//   addr_lo     in  low two address bits (lane select)
//   rs2         in  raw store data
//   rdata       in  raw 32-bit word read from memory
//   byte_enable out store byte lanes
//   wdata       out lane-aligned store data
//   load_data   out extracted and sign/zero-extended load value
module mem_access_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        byte_enable = 4'hF;
        wdata       = rs2;
        case (funct3[1:0])
            2'b00: begin
                byte_enable = 4'b0001 << addr_lo;
                wdata       = rs2 << {addr_lo, 3'b000};
            end
            2'b01: begin
                byte_enable = 4'b0011 << {addr_lo[1], 1'b0};
                wdata       = rs2 << {addr_lo[1], 4'b0000};
            end
            default: ;
        endcase
    end

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Module: mem_access
// MEM pipeline stage. Issues data-memory requests for the instruction held in
// regs_in, waits for the one-cycle dmem_resp pulse, formats load data and
// registers the bundle (with .mdr) for writeback.
//   clk, reset        clock; synchronous active-low reset
//   resp_a, stall_in  advance qualifiers from the I-side and downstream
//   stall_out         upstream stall (stall_in or memory not ready)
//   regs_in/regs_out  stage bundle in from execute / out to writeback
//   mem_exec          MEM->EX forwarding value (regs_in.alu)
//   dmem_*            data-memory request/response port
//   misalign          one-cycle misaligned-access pulse
// Optional feature: define MEM_MISALIGN_CHECK_EN to suppress misaligned
// half/word accesses and flag them on misalign; otherwise misalign is tied 0.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int width = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             resp_a,
    input  logic             stall_in,
    output logic             stall_out,
    input  stage_regs        regs_in,
    output stage_regs        regs_out,
    output logic [width-1:0] mem_exec,
    output logic [width-1:0] dmem_address,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [3:0]       dmem_byte_enable,
    output logic [width-1:0] dmem_wdata,
    input  logic [width-1:0] dmem_rdata,
    input  logic             dmem_resp,
    output logic             misalign
);

    mem_state_t  state, state_next;
    logic        memop, mis, active, req;
    logic        mem_ready, advance, capture;
    logic [31:0] rdata_hold, rdata_sel, load_data;
    stage_regs   regs_next;

    assign memop = regs_in.valid & (regs_in.ctrl.read_b | regs_in.ctrl.write);

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis = memop & access_misaligned(regs_in.funct3, regs_in.alu[1:0]);
`else
    assign mis = 1'b0;
`endif

    // An instruction that actually touches memory.
    assign active    = memop & ~mis;
    assign mem_ready = ~active | dmem_resp | (state == DONE);
    assign advance   = resp_a & ~stall_in & mem_ready;
    assign stall_out = stall_in | ~mem_ready;
    assign mem_exec  = regs_in.alu;

    // Once the response is in DONE the request is dropped so it is never
    // re-issued; reset also masks the strobes directly.
    assign req          = active & (state != DONE) & reset;
    assign dmem_read    = req & regs_in.ctrl.read_b;
    assign dmem_write   = req & regs_in.ctrl.write;
    assign dmem_address = {regs_in.alu[31:2], 2'b00};

    // Data arriving while the stage cannot advance comes from the hold register.
    assign rdata_sel = (state == DONE) ? rdata_hold : dmem_rdata;

    mem_access_align u_align (
        .funct3      (regs_in.funct3),
        .addr_lo     (regs_in.alu[1:0]),
        .rs2         (regs_in.rs2),
        .rdata       (rdata_sel),
        .byte_enable (dmem_byte_enable),
        .wdata       (dmem_wdata),
        .load_data   (load_data)
    );

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE, BUSY: begin
                if (!active) begin
                    state_next = IDLE;
                end else if (dmem_resp) begin
                    if (advance) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DONE;
                        capture    = 1'b1;
                    end
                end else begin
                    state_next = BUSY;
                end
            end
            DONE:    if (advance) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        regs_next     = regs_in;
        regs_next.mdr = (active & regs_in.ctrl.read_b) ? load_data : 32'h0;
        if (mis) regs_next.ctrl.load_regfile = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            regs_out <= '0;
        end else begin
            state <= state_next;
            if (advance) regs_out <= regs_next;
        end
    end

    // NOTE: the hold register is pure data, only read in DONE after a capture,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) rdata_hold <= dmem_rdata;
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) misalign <= 1'b0;
        else        misalign <= advance & mis;
    end
`else
    assign misalign = 1'b0;
`endif

endmodule
